xnor_match_counter: RTL and testbench

//  Multi-cycle bit-match unit for the 32-bit RISC datapath; consumes the per-bit XNOR word.

---
 rtl/xnor_match_counter_pkg.sv | 16 +
 rtl/xnor_match_counter_if.sv | 38 +++
 rtl/xnor_match_counter_popcount_step.sv | 21 ++
 rtl/xnor_match_counter.sv | 114 +++++++++++
 tb/tb_xnor_match_counter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/xnor_match_counter_pkg.sv
// xnor_pkg: shared FSM state encoding and default geometry for the XNOR match counter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package xnor_pkg;

  // Default operand width and bits counted per COUNT cycle.
  localparam int XNOR_WIDTH = 32;
  localparam int XNOR_STEP  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage : xnor_pkg

// File: rtl/xnor_match_counter_if.sv
// xnor_match_counter_if: operand and result handshakes plus abort for the match counter.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry flow control in each direction.
// Ports (slave view, i.e. the unit):
//   in:  in_valid, A, B, abort, out_ready
//   out: in_ready, out_valid, Result, match_count, equal
interface xnor_match_counter_if
  import xnor_pkg::*;
#(
  parameter int WIDTH = XNOR_WIDTH
) ();

  localparam int CW = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic [CW-1:0]    match_count;
  logic             equal;

  // Producer/consumer side.
  modport master (
    output in_valid, A, B, abort, out_ready,
    input  in_ready, out_valid, Result, match_count, equal
  );

  // Match counter side.
  modport slave (
    input  in_valid, A, B, abort, out_ready,
    output in_ready, out_valid, Result, match_count, equal
  );

endinterface : xnor_match_counter_if

// File: rtl/xnor_match_counter_popcount_step.sv
// popcount_step: counts the 1 bits of a STEP-bit slice.
// Latency: combinational.
// Backpressure: none.
// Ports: bits_i (STEP bits in), count_o ($clog2(STEP+1) bits out).
module popcount_step #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0]            bits_i,
  output logic [$clog2(STEP+1)-1:0]  count_o
);

  localparam int PCW = $clog2(STEP + 1);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < STEP; i++) begin
      count_o = count_o + PCW'(bits_i[i]);
    end
  end

endmodule : popcount_step

// File: rtl/xnor_match_counter.sv
// xnor_match_counter: registers ~(A^B) and counts its matching bits STEP bits per cycle.
// Latency: accept at edge 0, out_valid high after edge WIDTH/STEP.
// Backpressure: in_ready only in IDLE; DONE holds all outputs until out_ready (or abort).
// Ports: clk, reset_n (async active-low), bus (xnor_match_counter_if.slave).
module xnor_match_counter
  import xnor_pkg::*;
#(
  parameter int WIDTH = XNOR_WIDTH,
  parameter int STEP  = XNOR_STEP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  xnor_match_counter_if.slave   bus
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int PCW    = $clog2(STEP + 1);
  localparam int NSTEPS = WIDTH / STEP;
  // Keep idx at least one bit wide so the single-step case still elaborates.
  localparam int IDX_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTEPS - 1);

  generate
    if (WIDTH < 1 || STEP < 1 || (WIDTH % STEP) != 0) begin : g_bad_geometry
      $error("xnor_match_counter: WIDTH must be >= 1 and a multiple of STEP");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             equal_q, equal_d;
  logic [PCW-1:0]   step_cnt;

  popcount_step #(
    .STEP (STEP)
  ) u_popcount_step (
    .bits_i  (shift_q[STEP-1:0]),
    .count_o (step_cnt)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    shift_d  = shift_q;
    count_d  = count_q;
    idx_d    = idx_q;
    equal_d  = equal_q;

    case (state_q)
      S_IDLE: begin
        // abort beats in_valid: nothing is accepted in that cycle.
        if (bus.in_valid && !bus.abort) begin
          result_d = ~(bus.A ^ bus.B);
          shift_d  = ~(bus.A ^ bus.B);
          count_d  = '0;
          idx_d    = '0;
          equal_d  = 1'b0;
          state_d  = S_COUNT;
        end
      end

      S_COUNT: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          count_d = count_q + CW'(step_cnt);
          shift_d = shift_q >> STEP;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            equal_d = (count_d == CW'(WIDTH));
          end
        end
      end

      S_DONE: begin
        // A same-cycle out_ready completes the transfer even when abort is high.
        if (bus.out_ready || bus.abort) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      shift_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      equal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      equal_q  <= equal_d;
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE);
  assign bus.out_valid   = (state_q == S_DONE);
  assign bus.Result      = result_q;
  assign bus.match_count = count_q;
  assign bus.equal       = equal_q;

endmodule : xnor_match_counter

// File: tb/tb_xnor_match_counter.sv
// tb_xnor_match_counter: randomized and directed checks of xnor_match_counter against
// a behavioural model built from $countones over ~(A^B).
module tb_xnor_match_counter;

  localparam int WIDTH  = 32;
  localparam int STEP   = 4;
  localparam int EXP_LAT = WIDTH / STEP;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] last_result;
  logic [5:0]  last_count;
  logic        last_equal;

  xnor_match_counter_if #(.WIDTH(WIDTH)) bus ();

  xnor_match_counter #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_in_ready();
    int w;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_val("in_ready_before_op", 32'(bus.in_ready), 32'd1);
  endtask

  // Drives one operand pair through the handshake and leaves the bench at the
  // negedge right after the accept edge.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b);
    wait_in_ready();
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Scramble operands: they must only be sampled at accept.
    bus.A        = $urandom();
    bus.B        = $urandom();
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] exp_res;
    int          exp_cnt;
    int          lat;
    exp_res = ~(a ^ b);
    exp_cnt = $countones(exp_res);
    accept_op(a, b);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check_val("latency", 32'(lat), 32'(EXP_LAT));
    check_val("result", bus.Result, exp_res);
    check_val("match_count", 32'(bus.match_count), 32'(exp_cnt));
    check_val("equal", 32'(bus.equal), 32'(exp_cnt == WIDTH));
    check_val("in_ready_done", 32'(bus.in_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check_val("stall_valid", 32'(bus.out_valid), 32'd1);
      check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check_val("stall_result", bus.Result, exp_res);
      check_val("stall_count", 32'(bus.match_count), 32'(exp_cnt));
      check_val("stall_equal", 32'(bus.equal), 32'(exp_cnt == WIDTH));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_val("post_xfer_valid", 32'(bus.out_valid), 32'd0);
    check_val("post_xfer_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("idle_result_kept", bus.Result, exp_res);
    check_val("idle_count_kept", 32'(bus.match_count), 32'(exp_cnt));
    last_result = exp_res;
    last_count  = 6'(exp_cnt);
    last_equal  = (exp_cnt == WIDTH);
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check_val(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int          mode;
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_result", bus.Result, 32'd0);
    check_val("rst_count", 32'(bus.match_count), 32'd0);
    check_val("rst_equal", 32'(bus.equal), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed boundary patterns.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 0);
    run_op(32'h1234_5678, 32'h1234_5679, 5);

    // Abort mid-count: sampled on edge 3 after accept.
    accept_op(32'hDEAD_BEEF, 32'h1234_5678);
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    check_val("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("abort_in_ready", 32'(bus.in_ready), 32'd1);
    expect_quiet("abort_no_valid", 12);

    // in_valid together with abort in IDLE: nothing is accepted.
    bus.A        = 32'h0F0F_0F0F;
    bus.B        = 32'h0F0F_0F0F;
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    check_val("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);
    expect_quiet("abort_idle_no_valid", 12);
    check_val("abort_idle_result_kept", bus.Result, ~(32'hDEAD_BEEF ^ 32'h1234_5678));

    // Async reset mid-count.
    accept_op(32'hFFFF_0000, 32'hFFFF_0000);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_count", 32'(bus.match_count), 32'd0);
    check_val("midrst_result", bus.Result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    expect_quiet("midrst_no_valid", 10);
    run_op(32'hAAAA_AAAA, 32'h5555_5555, 1);

    // Randomized operands with match-heavy patterns mixed in.
    for (int n = 0; n < 25; n++) begin
      a    = $urandom();
      mode = $urandom_range(0, 2);
      case (mode)
        0:       b = $urandom();
        1:       b = a;
        default: b = a ^ (32'd1 << $urandom_range(0, 31));
      endcase
      run_op(a, b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_xnor_match_counter
